// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset datapath: encodings,
// ALU control codes, controller states and small decode helpers.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7
    } alu_ctl_e;

    typedef enum logic [2:0] {
        ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_e;

    function automatic alu_ctl_e funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
        case (opcode)
            OP_RTYPE: return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_ADDI, OP_LW, OP_SW, OP_BEQ: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU shared by branch-target, address and R-type computation.
module mc_alu
    import mc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_ctl_e            ctl,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   y,
    output logic                zero
);

    always_comb begin
        case (ctl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SUB: y = a - b;
            ALU_SLT: y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = a + b;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset datapath: FSM-sequenced FETCH/DECODE/EXEC/MEM/WB over
// one shared memory port with a req/ready handshake.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int               DATA_W   = 32,
    parameter int               ADDR_W   = 16,
    parameter int               NREGS    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                retire,
    output logic                halted,
    output logic [ADDR_W-1:0]   dbg_pc
);

    localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic                retire_q, retire_d;
    logic [DATA_W-1:0]   regs_q [NREGS];

    logic                rf_we;
    logic [RIDX_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;

    logic [5:0]          opcode, funct;
    logic [RIDX_W-1:0]   rs, rt, rd;
    logic [DATA_W-1:0]   imm_sext;
    logic                is_sw;

    alu_ctl_e            alu_ctl;
    logic [DATA_W-1:0]   alu_a, alu_b, alu_y;
    logic                alu_zero;
    logic                unused_ir_bits;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs       = ir_q[21 +: RIDX_W];
    assign rt       = ir_q[16 +: RIDX_W];
    assign rd       = ir_q[11 +: RIDX_W];
    assign imm_sext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign is_sw    = (opcode == OP_SW);
    assign unused_ir_bits = ^ir_q[25:6];

    // In DECODE the ALU forms the branch target from the already-incremented PC.
    always_comb begin
        alu_ctl = ALU_ADD;
        alu_a   = a_q;
        alu_b   = imm_sext;
        if (state_q == ST_DECODE) begin
            alu_a = DATA_W'(pc_q);
            alu_b = imm_sext << 2;
        end else if (opcode == OP_RTYPE) begin
            alu_ctl = funct_to_alu(funct);
            alu_b   = b_q;
        end else if (opcode == OP_BEQ) begin
            alu_ctl = ALU_SUB;
            alu_b   = b_q;
        end
    end

    mc_alu #(.DATA_W(DATA_W)) u_alu (
        .ctl  (alu_ctl),
        .a    (alu_a),
        .b    (alu_b),
        .y    (alu_y),
        .zero (alu_zero)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        retire_d  = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = alu_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                alu_d   = alu_y;
                state_d = is_legal(opcode, funct) ? ST_EXEC : ST_HALT;
            end
            ST_EXEC: begin
                if (opcode == OP_BEQ) begin
                    if (alu_zero) pc_d = alu_q[ADDR_W-1:0];
                    retire_d = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    alu_d   = alu_y;
                    state_d = (opcode == OP_LW || is_sw) ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                mem_req   = 1'b1;
                mem_we    = is_sw;
                mem_addr  = {alu_q[ADDR_W-1:2], 2'b00};
                mem_wdata = is_sw ? b_q : '0;
                if (mem_ready) begin
                    if (is_sw) begin
                        retire_d = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
                rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
                retire_d = 1'b1;
                state_d  = ST_FETCH;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RST;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            retire_q <= retire_d;
        end
    end

    // R0 is never written, so it keeps its reset value of zero.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs_q[gi] <= '0;
            end else if (rf_we && (gi != 0) && (rf_waddr == RIDX_W'(gi))) begin
                regs_q[gi] <= rf_wdata;
            end
        end
    end

    assign retire = retire_q;
    assign halted = (state_q == ST_HALT);
    assign dbg_pc = pc_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: memory model with programmable wait states,
// program tables per scenario, checks on stores, retire timing and bus behaviour.
module tb_mc_datapath;

    localparam logic [5:0] T_ADDI = 6'h08, T_LW = 6'h23, T_SW = 6'h2B, T_BEQ = 6'h04;
    localparam logic [5:0] T_ADD = 6'h20, T_SUB = 6'h22, T_AND = 6'h24, T_OR = 6'h25, T_SLT = 6'h2A;
    localparam logic [31:0] NOP = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [15:0] mem_addr, dbg_pc;
    logic [31:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int waits = 0;
    int wcnt = 0;
    int gen = 1;

    logic [31:0] mem  [256];
    logic [31:0] dmem [256];
    int          wgen [256];

    int          ret_cyc[$];
    logic [15:0] ret_addr[$];
    logic [15:0] wl_addr[$];
    logic [31:0] wl_data[$];

    logic        hold_v = 1'b0;
    logic [48:0] hold_bus = '0;
    int          hold_chk = 0;
    int          unstable = 0;

    mc_datapath #(.DATA_W(32), .ADDR_W(16), .NREGS(32), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .retire    (retire),
        .halted    (halted),
        .dbg_pc    (dbg_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every transfer sees exactly 'waits' not-ready cycles before completing.
    assign mem_ready = mem_req && (wcnt >= waits);
    assign mem_rdata = (wgen[mem_addr[9:2]] == gen) ? dmem[mem_addr[9:2]] : mem[mem_addr[9:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_we && mem_ready) begin
            dmem[mem_addr[9:2]] <= mem_wdata;
            wgen[mem_addr[9:2]] <= gen;
            wl_addr.push_back(mem_addr);
            wl_data.push_back(mem_wdata);
            $display("[cyc %0d] store addr=%h data=%h", cyc, mem_addr, mem_wdata);
        end
    end

    always @(negedge clk) begin
        if (retire) begin
            ret_cyc.push_back(cyc);
            ret_addr.push_back(mem_addr);
        end
        if (mem_req && !mem_ready) begin
            if (hold_v) begin
                hold_chk <= hold_chk + 1;
                if ({mem_we, mem_addr, mem_wdata} !== hold_bus) unstable <= unstable + 1;
            end
            hold_v   <= 1'b1;
            hold_bus <= {mem_we, mem_addr, mem_wdata};
        end else begin
            hold_v <= 1'b0;
        end
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic hold_reset();
        rst_n = 1'b0;
        gen   = gen + 1;
        for (int i = 0; i < 256; i++) mem[i] = NOP;
        @(negedge clk);
    endtask

    // Returns at the negedge of the first FETCH cycle.
    task automatic release_reset(input int w);
        waits = w;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        hold_reset();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        total++; if (retire !== 1'b0) begin bad++; $display("FAIL rst_retire: got %b want 0", retire); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", halted); end
        total++; if (dbg_pc !== 16'h0000) begin bad++; $display("FAIL rst_pc: got %h want 0000", dbg_pc); end
        total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr: got %h want 0000", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        release_reset(0);
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL first_req: got %b want 1", mem_req); end
        total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL first_addr: got %h want 0000", mem_addr); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL first_we: got %b want 0", mem_we); end
    endtask

    task automatic test_alu_prog();
        logic [15:0] ea [6];
        logic [31:0] ed [6];
        int wb, rb, f0;
        ea = '{16'h40, 16'h44, 16'h48, 16'h4C, 16'h50, 16'h54};
        ed = '{32'd2, 32'd1, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd0};
        hold_reset();
        mem[0]  = enc_i(T_ADDI, 0, 1, 5);
        mem[1]  = enc_i(T_ADDI, 0, 2, -3);
        mem[2]  = enc_r(1, 2, 3, T_ADD);
        mem[3]  = enc_r(2, 1, 4, T_SLT);
        mem[4]  = enc_i(T_SW, 0, 3, 'h40);
        mem[5]  = enc_i(T_SW, 0, 4, 'h44);
        mem[6]  = enc_r(1, 2, 7, T_SUB);
        mem[7]  = enc_r(1, 2, 8, T_AND);
        mem[8]  = enc_r(1, 2, 9, T_OR);
        mem[9]  = enc_r(1, 2, 10, T_SLT);
        mem[10] = enc_i(T_SW, 0, 7, 'h48);
        mem[11] = enc_i(T_SW, 0, 8, 'h4C);
        mem[12] = enc_i(T_SW, 0, 9, 'h50);
        mem[13] = enc_i(T_SW, 0, 10, 'h54);
        wb = wl_addr.size();
        rb = ret_cyc.size();
        release_reset(0);
        f0 = cyc;
        for (int t = 0; t < 300 && wl_addr.size() < wb + 6; t++) @(negedge clk);
        total++;
        if (wl_addr.size() < wb + 6) begin
            bad++; $display("FAIL alu_stores_timeout: got %0d stores want 6", wl_addr.size() - wb);
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (wl_addr[wb+i] !== ea[i] || wl_data[wb+i] !== ed[i]) begin
                    bad++; $display("FAIL alu_store%0d: got %h/%h want %h/%h", i, wl_addr[wb+i], wl_data[wb+i], ea[i], ed[i]);
                end
            end
            total++;
            if (ret_cyc[rb] - f0 != 4) begin bad++; $display("FAIL alu_first_lat: got %0d want 4", ret_cyc[rb] - f0); end
            for (int i = 1; i < 6; i++) begin
                total++;
                if (ret_cyc[rb+i] - ret_cyc[rb+i-1] != 4) begin
                    bad++; $display("FAIL alu_lat%0d: got %0d want 4", i, ret_cyc[rb+i] - ret_cyc[rb+i-1]);
                end
            end
        end
    endtask

    task automatic test_lwsw_wait();
        int wb, rb, hb, ub;
        hold_reset();
        mem[0]  = enc_i(T_ADDI, 0, 1, 5);
        mem[1]  = enc_i(T_BEQ, 0, 0, 6);
        mem[8]  = enc_i(T_SW, 0, 1, 8);
        mem[9]  = enc_i(T_LW, 0, 5, 8);
        mem[10] = enc_i(T_SW, 0, 5, 'h40);
        mem[11] = enc_i(T_LW, 0, 6, 11);
        mem[12] = enc_i(T_SW, 0, 6, 'h44);
        wb = wl_addr.size();
        rb = ret_cyc.size();
        hb = hold_chk;
        ub = unstable;
        release_reset(3);
        for (int t = 0; t < 400 && wl_addr.size() < wb + 3; t++) @(negedge clk);
        total++;
        if (wl_addr.size() < wb + 3) begin
            bad++; $display("FAIL lwsw_timeout: got %0d stores want 3", wl_addr.size() - wb);
        end else begin
            total++; if (wl_addr[wb] !== 16'h0008 || wl_data[wb] !== 32'd5) begin
                bad++; $display("FAIL sw_word: got %h/%h want 0008/00000005", wl_addr[wb], wl_data[wb]); end
            total++; if (wl_data[wb+1] !== 32'd5) begin
                bad++; $display("FAIL lw_value: got %h want 00000005", wl_data[wb+1]); end
            total++; if (wl_data[wb+2] !== 32'd5) begin
                bad++; $display("FAIL lw_unaligned: got %h want 00000005", wl_data[wb+2]); end
            total++; if (ret_cyc[rb+2] - ret_cyc[rb+1] != 10) begin
                bad++; $display("FAIL sw_lat: got %0d want 10", ret_cyc[rb+2] - ret_cyc[rb+1]); end
            total++; if (ret_cyc[rb+3] - ret_cyc[rb+2] != 11) begin
                bad++; $display("FAIL lw_lat: got %0d want 11", ret_cyc[rb+3] - ret_cyc[rb+2]); end
            total++; if (hold_chk - hb < 10) begin
                bad++; $display("FAIL wait_seen: got %0d holds want >=10", hold_chk - hb); end
            total++; if (unstable != ub) begin
                bad++; $display("FAIL bus_stable: got %0d changes want 0", unstable - ub); end
        end
    endtask

    task automatic test_beq();
        for (int k = 0; k < 2; k++) begin
            int rb;
            logic [15:0] want;
            want = (k == 0) ? 16'h0000 : 16'h0014;
            hold_reset();
            mem[0] = enc_i(T_ADDI, 0, 1, 7);
            mem[1] = enc_i(T_ADDI, 0, 2, (k == 0) ? 7 : 8);
            mem[4] = enc_i(T_BEQ, 1, 2, -5);
            rb = ret_cyc.size();
            release_reset(0);
            for (int t = 0; t < 100 && ret_cyc.size() < rb + 6; t++) @(negedge clk);
            total++;
            if (ret_cyc.size() < rb + 6) begin
                bad++; $display("FAIL beq%0d_timeout: got %0d retires want 6", k, ret_cyc.size() - rb);
            end else begin
                total++; if (ret_addr[rb+4] !== want) begin
                    bad++; $display("FAIL beq%0d_target: got %h want %h", k, ret_addr[rb+4], want); end
                total++; if (ret_cyc[rb+4] - ret_cyc[rb+3] != 3) begin
                    bad++; $display("FAIL beq%0d_lat: got %0d want 3", k, ret_cyc[rb+4] - ret_cyc[rb+3]); end
            end
        end
    endtask

    task automatic test_r0_halt();
        int wb, rb, nreq, nret;
        hold_reset();
        mem[0] = enc_i(T_ADDI, 0, 1, 9);
        mem[1] = enc_r(1, 1, 0, T_ADD);
        mem[2] = enc_r(0, 0, 6, T_ADD);
        mem[3] = enc_i(T_SW, 0, 6, 'h40);
        mem[4] = 32'hFC00_0000;
        wb = wl_addr.size();
        rb = ret_cyc.size();
        release_reset(0);
        for (int t = 0; t < 100 && halted !== 1'b1; t++) @(negedge clk);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_set: got %b want 1", halted); end
        total++; if (wl_addr.size() != wb + 1 || wl_data[wb] !== 32'd0) begin
            bad++; $display("FAIL r0_write: got %0d stores last=%h want 1 store of 0", wl_addr.size() - wb, wl_data[wl_data.size()-1]); end
        nreq = 0;
        nret = ret_cyc.size();
        repeat (20) begin
            @(negedge clk);
            if (mem_req !== 1'b0) nreq++;
        end
        total++; if (nreq != 0) begin bad++; $display("FAIL halt_req: got %0d req cycles want 0", nreq); end
        total++; if (ret_cyc.size() != rb + 4 || nret != rb + 4) begin
            bad++; $display("FAIL halt_retires: got %0d want 4", ret_cyc.size() - rb); end
        total++; if (dbg_pc !== 16'h0014) begin bad++; $display("FAIL halt_pc: got %h want 0014", dbg_pc); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_sticky: got %b want 1", halted); end
    endtask

    task automatic test_illegal_funct();
        int rb;
        hold_reset();
        mem[0] = enc_r(1, 1, 1, 6'h21);
        rb = ret_cyc.size();
        release_reset(0);
        for (int t = 0; t < 20 && halted !== 1'b1; t++) @(negedge clk);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL funct_halt: got %b want 1", halted); end
        total++; if (ret_cyc.size() != rb) begin bad++; $display("FAIL funct_retire: got %0d want 0", ret_cyc.size() - rb); end
        total++; if (dbg_pc !== 16'h0004) begin bad++; $display("FAIL funct_pc: got %h want 0004", dbg_pc); end
    endtask

    task automatic test_reset_mid();
        int rb;
        logic found;
        hold_reset();
        mem[0] = enc_i(T_ADDI, 0, 1, 5);
        mem[1] = enc_i(T_LW, 0, 5, 'h40);
        rb = ret_cyc.size();
        release_reset(3);
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 16'h0040) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL mid_lw_seen: got 0 want 1"); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_req_drop: got %b want 0", mem_req); end
        total++; if (dbg_pc !== 16'h0000) begin bad++; $display("FAIL mid_pc: got %h want 0000", dbg_pc); end
        total++; if (ret_cyc.size() != rb + 1) begin bad++; $display("FAIL mid_retires: got %0d want 1", ret_cyc.size() - rb); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0000) begin
            bad++; $display("FAIL mid_refetch: got req=%b we=%b addr=%h want 1/0/0000", mem_req, mem_we, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_alu_prog();
        test_lwsw_wait();
        test_beq();
        test_r0_halt();
        test_illegal_funct();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
